// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, qualifies lock stability, and
// gates the downstream reset; retries on timeout and latches a fault when retries run out.
module pll_lock_supervisor #(
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 1000000,
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] unlock_events
);

  localparam int unsigned PW = $clog2(RST_PULSE_CYC + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  unlock_q, unlock_d;
  logic        pll_rst_q, pll_rst_d;
  logic        sys_rst_n_q, sys_rst_n_d;
  logic        locked_q, locked_d;
  logic        fault_q, fault_d;

  logic        lock_s;
  logic        timeout_hit;
  logic [3:0]  retry_inc;
  logic        retry_full;

  assign lock_s      = sync_q[1];
  assign timeout_hit = (timeout_q == TW'(LOCK_TIMEOUT_CYC - 1));
  assign retry_inc   = retry_q + 4'd1;
  assign retry_full  = (retry_inc == 4'(MAX_RETRIES));

  // Next-state, counters and state-decoded registered outputs
  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], pll_lock};
    pulse_d   = pulse_q;
    stable_d  = stable_q;
    timeout_d = timeout_q;
    retry_d   = retry_q;
    unlock_d  = unlock_q;

    case (state_q)
      S_PLL_RST: begin
        stable_d  = '0;
        timeout_d = '0;
        if (pulse_q == PW'(RST_PULSE_CYC - 1)) begin
          pulse_d = '0;
          state_d = S_WAIT_LOCK;
        end else begin
          pulse_d = pulse_q + PW'(1);
        end
      end
      S_WAIT_LOCK: begin
        timeout_d = timeout_q + TW'(1);
        if (timeout_hit) begin
          retry_d = retry_inc;
          state_d = retry_full ? S_FAULT : S_PLL_RST;
        end else if (lock_s) begin
          stable_d = SW'(1);
          state_d  = S_STABLE;
        end
      end
      S_STABLE: begin
        timeout_d = timeout_q + TW'(1);
        // Stable-complete takes priority over a coincident timeout
        if (lock_s && (stable_q == SW'(LOCK_STABLE_CYC))) begin
          stable_d  = '0;
          timeout_d = '0;
          retry_d   = '0;
          state_d   = S_RUN;
        end else if (timeout_hit) begin
          retry_d = retry_inc;
          state_d = retry_full ? S_FAULT : S_PLL_RST;
        end else if (!lock_s) begin
          stable_d = '0;
          state_d  = S_WAIT_LOCK;
        end else begin
          stable_d = stable_q + SW'(1);
        end
      end
      S_RUN: begin
        retry_d = '0;
        if (!lock_s) begin
          if (unlock_q != 8'hFF) unlock_d = unlock_q + 8'd1;
          state_d = S_PLL_RST;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d   = S_PLL_RST;
        pulse_d   = '0;
        stable_d  = '0;
        timeout_d = '0;
      end
    endcase

    pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAULT);
    sys_rst_n_d = (state_d == S_RUN);
    locked_d    = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PLL_RST;
      sync_q      <= '0;
      pulse_q     <= '0;
      stable_q    <= '0;
      timeout_q   <= '0;
      retry_q     <= '0;
      unlock_q    <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      pulse_q     <= pulse_d;
      stable_q    <= stable_d;
      timeout_q   <= timeout_d;
      retry_q     <= retry_d;
      unlock_q    <= unlock_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign locked        = locked_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign unlock_events = unlock_q;

endmodule
